// File: rtl/mem_access_unit.sv
// Load/store unit with internal data memory and a fixed access latency.
// One request is in flight at a time: IDLE accepts, WAIT counts down, RESP pulses resp_valid.
module mem_access_unit #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256,
    parameter int LATENCY       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic                     req_byte,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     busy
);
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(8'hFF);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;

    logic                     lat_write;
    logic                     lat_byte;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;

    logic                     acc_write;
    logic                     acc_byte;
    logic [ADDRESS_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0]    acc_wdata;
    logic [IDX_W-1:0]         acc_idx;
    logic                     acc_err;
    logic                     do_access;
    logic [DATA_WIDTH-1:0]    mem_word;
    logic [DATA_WIDTH-1:0]    wr_word;
    logic [DATA_WIDTH-1:0]    rd_word;

    logic [DATA_WIDTH-1:0]    mem [MEM_SIZE];

    // With single-cycle latency the access happens on the acceptance edge, so the live inputs are used.
    always_comb begin
        if (LATENCY == 1) begin
            acc_write = req_write;
            acc_byte  = req_byte;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_write = lat_write;
            acc_byte  = lat_byte;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
        end
    end

    assign do_access = ((LATENCY == 1) && (state == IDLE) && req_valid)
                     || ((state == WAIT) && (cnt == '0));
    assign acc_err   = ({1'b0, acc_addr} >= (ADDRESS_WIDTH + 1)'(MEM_SIZE));
    assign acc_idx   = acc_addr[IDX_W-1:0];
    assign mem_word  = mem[acc_idx];
    assign wr_word   = acc_byte ? ((mem_word & ~BYTE_MASK) | (acc_wdata & BYTE_MASK)) : acc_wdata;
    assign rd_word   = acc_byte ? (mem_word & BYTE_MASK) : mem_word;

    // Memory is not reset; rst gates the write so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (do_access && !rst && acc_write && !acc_err) begin
            mem[acc_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            lat_write <= req_write;
            lat_byte  <= req_byte;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (do_access) begin
                state      <= RESP;
                req_ready  <= 1'b0;
                busy       <= 1'b1;
                resp_valid <= 1'b1;
                resp_err   <= acc_err;
                resp_rdata <= (acc_write || acc_err) ? '0 : rd_word;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            state     <= WAIT;
                            cnt       <= CNT_LOAD;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    WAIT: cnt <= cnt - CNT_W'(1);
                    RESP: begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
